inv_share_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one single-bit `Inv` cell (ports `A`, `Y`) among `N_REQ` requesters. Each requester submits a `WIDTH`-bit word. The block grants one requester at a time, streams the word bit-serially through the shared inverter, and returns the inverted word with the requester's id. It sits between requester logic and the shared inverter datapath and is the only driver of the inverter's `A` input.

---
 rtl/inv_share_arbiter.sv | 123 ++++++++++++
 tb/tb_inv_share_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/inv_share_arbiter.sv
// Round-robin sequencer sharing one single-bit Inv cell among N_REQ requesters:
// accepts one word, pushes it LSB-first through the inverter, returns the result with its id.
module inv_share_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   rsp_valid,
  output logic [ID_W-1:0]        rsp_id,
  output logic [WIDTH-1:0]       rsp_data,
  output logic                   busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  // Handshake: a word moves on the rising edge where req_valid[i] and
  // req_ready[i] are both high; req_ready is one-hot and only asserted in IDLE.
  // The response side has no back-pressure: rsp_valid is a single-cycle pulse.

  logic [1:0]       state;
  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  id;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] rreg;
  logic [WIDTH-1:0] rreg_next;
  logic             inv_y;

  logic             grant_found;
  logic [ID_W-1:0]  grant_idx;
  logic [ID_W-1:0]  cand;
  logic [WIDTH-1:0] grant_word;

  Inv u_inv (
    .A (sreg[0]),
    .Y (inv_y)
  );

  // Scan starting at ptr; the index adder wraps naturally because N_REQ is a power of two.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = ptr + ID_W'(k);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign grant_word = req_data[grant_idx*WIDTH +: WIDTH];
  assign rreg_next  = {inv_y, rreg[WIDTH-1:1]};
  assign busy       = (state != S_IDLE);

  always_comb begin
    req_ready = '0;
    if (rst_n && state == S_IDLE && grant_found) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      ptr       <= '0;
      id        <= '0;
      cnt       <= '0;
      sreg      <= '0;
      rreg      <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (grant_found) begin
            sreg  <= grant_word;
            id    <= grant_idx;
            ptr   <= grant_idx + ID_W'(1);
            cnt   <= '0;
            state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          rreg <= rreg_next;
          sreg <= {1'b0, sreg[WIDTH-1:1]};
          cnt  <= cnt + CNT_W'(1);
          // Result is registered on the last shift so it is visible during DONE.
          if (cnt == CNT_LAST) begin
            state     <= S_DONE;
            rsp_valid <= 1'b1;
            rsp_data  <= rreg_next;
            rsp_id    <= id;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// Shared single-bit inverter cell.
module Inv (
  input  logic A,
  output logic Y
);
  assign Y = ~A;
endmodule

// File: tb/tb_inv_share_arbiter.sv
// Directed bench for inv_share_arbiter: grant order, latency and response data
// are checked against a scoreboard filled at each observed accept.
module tb_inv_share_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int EW = 32 + 2 + W;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0] req_ready;
  logic         rsp_valid;
  logic [1:0]   rsp_id;
  logic [W-1:0] rsp_data;
  logic         busy;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_e;

  inv_share_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every rsp_valid pulse must match the oldest expected entry.
  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", 32'(rsp_id), 32'hFFFF_FFFF);
      end else begin
        mon_e = exp_q.pop_front();
        check("rsp_id", 32'(rsp_id), 32'(mon_e[W+1:W]));
        check("rsp_data", 32'(rsp_data), 32'(mon_e[W-1:0]));
        check("rsp_cycle", 32'(cyc), mon_e[EW-1:W+2]);
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input int i, input logic [W-1:0] d);
    req_data[i*W +: W] = d;
  endtask

  // Wait for a grant, check it against g and the expected idle gap, then
  // record the response due WIDTH+1 cycles after the accept edge.
  task automatic expect_grant(input int g, input logic [W-1:0] d, input int exp_wait);
    int w = 0;
    bit got = 1'b0;
    logic [31:0] one_hot;
    logic [31:0] due;
    logic [1:0]  gi;
    while (w < 40) begin
      @(negedge clk);
      if (req_ready != '0) begin
        got = 1'b1;
        break;
      end
      w++;
    end
    check("grant_seen", 32'(got), 32'd1);
    if (got) begin
      one_hot = 32'h1 << g;
      check("grant_onehot", 32'(req_ready), one_hot);
      check("grant_wait", 32'(w), 32'(exp_wait));
      check("idle_busy", 32'(busy), 32'd0);
      due = 32'(cyc + W + 1);
      gi  = 2'(g);
      exp_q.push_back({due, gi, ~d});
      tick();
      req_valid[g] = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd0);
    tick();
    tick();
    exp_q.delete();
    rst_n = 1'b1;
  endtask

  logic [W-1:0] d0, d1, d2, d3;
  int ready_cnt;

  initial begin
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    req_data  = '0;

    // 1: reset state with every requester asserting valid
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_ready", 32'(req_ready), 32'd0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_rsp_data", 32'(rsp_data), 32'd0);
    check("reset_rsp_id", 32'(rsp_id), 32'd0);
    tick();

    // 2: single request, busy for exactly WIDTH+1 cycles
    req_valid = 4'b0001;
    set_word(0, 8'hA5);
    rst_n = 1'b1;
    expect_grant(0, 8'hA5, 0);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      check("busy_window", 32'(busy), (i <= 9) ? 32'd1 : 32'd0);
    end
    check("rsp_hold_data", 32'(rsp_data), 32'h5A);
    check("rsp_hold_valid", 32'(rsp_valid), 32'd0);
    tick();

    // 3: all four simultaneous from a fresh pointer
    req_valid = 4'b1111;
    set_word(0, 8'h00);
    set_word(1, 8'hFF);
    set_word(2, 8'h0F);
    set_word(3, 8'h3C);
    do_reset();
    expect_grant(0, 8'h00, 0);
    expect_grant(1, 8'hFF, W + 1);
    expect_grant(2, 8'h0F, W + 1);
    expect_grant(3, 8'h3C, W + 1);

    // 4: fairness after granting 2
    d2 = 8'($urandom_range(0, 255));
    set_word(2, d2);
    req_valid[2] = 1'b1;
    expect_grant(2, d2, W + 1);
    d0 = 8'($urandom_range(0, 255));
    d3 = 8'($urandom_range(0, 255));
    set_word(0, d0);
    set_word(3, d3);
    req_valid[0] = 1'b1;
    req_valid[3] = 1'b1;
    expect_grant(3, d3, W + 1);
    expect_grant(0, d0, W + 1);

    // 5: reset in the 4th SHIFT cycle aborts and restarts at pointer 0
    d2 = 8'($urandom_range(0, 255));
    set_word(2, d2);
    req_valid[2] = 1'b1;
    expect_grant(2, d2, W + 1);
    tick();
    tick();
    tick();
    d1 = 8'($urandom_range(0, 255));
    d3 = 8'($urandom_range(0, 255));
    set_word(1, d1);
    set_word(3, d3);
    req_valid = 4'b1010;
    do_reset();
    expect_grant(1, d1, 0);
    expect_grant(3, d3, W + 1);

    // 6: requester 1 withdraws during another word's SHIFT
    d0 = 8'($urandom_range(0, 255));
    set_word(0, d0);
    req_valid[0] = 1'b1;
    expect_grant(0, d0, W + 1);
    tick();
    tick();
    set_word(1, 8'($urandom_range(0, 255)));
    req_valid[1] = 1'b1;
    tick();
    tick();
    tick();
    req_valid[1] = 1'b0;
    ready_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (req_ready != '0) ready_cnt++;
    end
    check("withdrawn_grants", 32'(ready_cnt), 32'd0);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
